// File: rtl/fetch_pkg.sv
// Shared constants and types for the instruction fetch stage.
package fetch_pkg;

  localparam int unsigned XLEN_DEFAULT       = 32;
  localparam logic [31:0] INITIAL_PC_DEFAULT = 32'h0000_1000;
  localparam logic [31:0] NOP_INSTR          = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN_DEFAULT-1:0] pc;
    logic [31:0]             instr;
  } fq_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with synchronous flush and an occupancy count.
module fetch_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;

  // Explicit wrap so non-power-of-two depths work too.
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop_i)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_i && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/fetch_queue_stage.sv
// Instruction fetch stage: credit-limited sequential fetch, in-flight PC
// tracking, fetch queue toward decode. FETCH_PERF_CNT_EN adds perf counters.
module fetch_queue_stage
  import fetch_pkg::*;
#(
  parameter int unsigned     XLEN            = XLEN_DEFAULT,
  parameter logic [XLEN-1:0] INITIAL_PC      = XLEN'(INITIAL_PC_DEFAULT),
  parameter int unsigned     QUEUE_DEPTH     = 4,
  parameter int unsigned     MAX_OUTSTANDING = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] fst_in_branch_address,
  input  logic            fst_in_branch_enable,
  output logic            fst_out_mem_req_valid,
  input  logic            fst_in_mem_req_ready,
  output logic [XLEN-1:0] fst_out_mem_req_addr,
  input  logic            fst_in_mem_resp_valid,
  input  logic [31:0]     fst_in_mem_resp_data,
  output logic            fst_out_valid,
  input  logic            fst_in_ready,
  output logic [31:0]     fst_out_instr,
  output logic [XLEN-1:0] fst_out_pc,
  output logic [XLEN-1:0] fst_out_pc_next
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]     fst_out_fetch_count,
  output logic [31:0]     fst_out_flush_count,
  output logic [31:0]     fst_out_stall_count
`endif
);

  localparam int unsigned CW  = $clog2(QUEUE_DEPTH + 1);
  localparam int unsigned PCW = $clog2(MAX_OUTSTANDING + 1);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
  } entry_t;

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [CW-1:0]   outstanding_q, outstanding_d;
  logic [CW-1:0]   drop_cnt_q, drop_cnt_d;
  logic            started_q;

  logic            redirect, req_fire, resp_live, q_push, q_pop;
  logic [CW-1:0]   q_count, occ, live_out;
  logic [CW:0]     credit_sum;
  logic [PCW-1:0]  pc_count;
  logic [XLEN-1:0] inflight_pc;
  entry_t          q_wdata, q_head;

  assign redirect  = fst_in_branch_enable;
  // Responses with nothing in flight (e.g. stragglers after reset) are ignored.
  assign resp_live = fst_in_mem_resp_valid && (outstanding_q != '0);
  assign live_out  = outstanding_q - drop_cnt_q;
  assign occ       = redirect ? '0 : q_count;
  assign credit_sum = {1'b0, occ} + {1'b0, live_out};

  assign fst_out_mem_req_valid = started_q
                              && (outstanding_q < CW'(MAX_OUTSTANDING))
                              && (credit_sum < (CW+1)'(QUEUE_DEPTH));
  assign fst_out_mem_req_addr  = redirect ? fst_in_branch_address : fetch_pc_q;
  assign req_fire = fst_out_mem_req_valid && fst_in_mem_req_ready;

  // A flush wins over both an incoming response and a decode pop.
  assign q_push = resp_live && (drop_cnt_q == '0) && !redirect;
  assign q_pop  = fst_out_valid && fst_in_ready && !redirect;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    if (req_fire)      fetch_pc_d = fst_out_mem_req_addr + XLEN'(4);
    else if (redirect) fetch_pc_d = fst_in_branch_address;
  end

  always_comb begin
    outstanding_d = outstanding_q;
    case ({req_fire, resp_live})
      2'b10:   outstanding_d = outstanding_q + 1'b1;
      2'b01:   outstanding_d = outstanding_q - 1'b1;
      default: outstanding_d = outstanding_q;
    endcase
  end

  // Everything issued before the redirect is stale; a response landing in
  // the redirect cycle is already consumed here.
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (redirect)                           drop_cnt_d = outstanding_q - CW'(resp_live);
    else if (resp_live && drop_cnt_q != '0) drop_cnt_d = drop_cnt_q - 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc_q    <= INITIAL_PC;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
      started_q     <= 1'b0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
      started_q     <= 1'b1;
    end
  end

  // In-flight PCs are popped by every response, dropped or not.
  fetch_fifo #(.WIDTH(XLEN), .DEPTH(MAX_OUTSTANDING)) u_pc_fifo (
    .clk     (clk),
    .reset   (reset),
    .flush_i (1'b0),
    .push_i  (req_fire),
    .wdata_i (fst_out_mem_req_addr),
    .pop_i   (resp_live),
    .rdata_o (inflight_pc),
    .count_o (pc_count)
  );

  assign q_wdata = '{pc: inflight_pc, instr: fst_in_mem_resp_data};

  fetch_fifo #(.WIDTH($bits(entry_t)), .DEPTH(QUEUE_DEPTH)) u_instr_q (
    .clk     (clk),
    .reset   (reset),
    .flush_i (redirect),
    .push_i  (q_push),
    .wdata_i (q_wdata),
    .pop_i   (q_pop),
    .rdata_o (q_head),
    .count_o (q_count)
  );

  assign fst_out_valid   = (q_count != '0);
  assign fst_out_instr   = fst_out_valid ? q_head.instr : NOP_INSTR;
  assign fst_out_pc      = fst_out_valid ? q_head.pc : fetch_pc_q;
  assign fst_out_pc_next = fst_out_pc + XLEN'(4);

  resp_fits_queue: assert property (@(posedge clk) disable iff (reset)
    !(q_push && q_count == CW'(QUEUE_DEPTH)));
  inflight_in_sync: assert property (@(posedge clk) disable iff (reset)
    CW'(pc_count) == outstanding_q);

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, flush_cnt_q, stall_cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_cnt_q <= '0;
      flush_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (q_push && fetch_cnt_q != '1)   fetch_cnt_q <= fetch_cnt_q + 1'b1;
      if (redirect && flush_cnt_q != '1) flush_cnt_q <= flush_cnt_q + 1'b1;
      if (!fst_out_valid && fst_in_ready && stall_cnt_q != '1)
        stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

  assign fst_out_fetch_count = fetch_cnt_q;
  assign fst_out_flush_count = flush_cnt_q;
  assign fst_out_stall_count = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_queue_stage.sv
// Scoreboard bench for fetch_queue_stage: random memory/decode/redirect traffic
// against a request-level reference model, plus directed corner cases.
module tb_fetch_queue_stage;
  import fetch_pkg::*;

  localparam int DEPTH = 4;
  localparam int MAXO  = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] br_addr = '0;
  logic        br_en = 1'b0;
  logic        mem_req_valid;
  logic        req_ready = 1'b0;
  logic [31:0] mem_req_addr;
  logic        resp_valid = 1'b0;
  logic [31:0] resp_data = '0;
  logic        out_valid;
  logic        dec_ready = 1'b0;
  logic [31:0] out_instr, out_pc, out_pc_next;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt, flush_cnt, stall_cnt;
`endif

  fetch_queue_stage #(.XLEN(32), .INITIAL_PC(32'h1000), .QUEUE_DEPTH(DEPTH),
                      .MAX_OUTSTANDING(MAXO)) dut (
    .clk                   (clk),
    .reset                 (reset),
    .fst_in_branch_address (br_addr),
    .fst_in_branch_enable  (br_en),
    .fst_out_mem_req_valid (mem_req_valid),
    .fst_in_mem_req_ready  (req_ready),
    .fst_out_mem_req_addr  (mem_req_addr),
    .fst_in_mem_resp_valid (resp_valid),
    .fst_in_mem_resp_data  (resp_data),
    .fst_out_valid         (out_valid),
    .fst_in_ready          (dec_ready),
    .fst_out_instr         (out_instr),
    .fst_out_pc            (out_pc),
    .fst_out_pc_next       (out_pc_next)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fst_out_fetch_count   (fetch_cnt),
    .fst_out_flush_count   (flush_cnt),
    .fst_out_stall_count   (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    bit          live;
    int          due;
  } pend_t;

  pend_t       pend[$];   // requests in flight at the memory
  fq_entry_t   sb[$];     // instructions decode is still owed, in order
  int          total = 0, bad = 0, cyc = 0, fires = 0;
  logic [31:0] exp_pc = 32'h1000;
  bit          started = 0, saw_zero = 0;
  int          k_req_rdy = 100, k_dec_rdy = 100, k_br = 0, k_resp = 100, lat_max = 0;
  bit          f_br = 0, f_resp = 0;
  logic [31:0] f_tgt = '0;
  int          late_cnt = 0;
  fq_entry_t   me;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock cycle, entered and left at a falling edge.
  task automatic step();
    bit late, br, resp, exp_v, fire;
    logic [31:0] tgt, exp_a;
    int live, term;
    pend_t p;
    fq_entry_t e;
    late = (late_cnt > 0);
    resp = 0;
    if (late) begin
      resp = 1; resp_data = $urandom; late_cnt--;
    end else if (pend.size() > 0 && pend[0].due <= cyc &&
                 (f_resp || ($urandom % 100) < k_resp)) begin
      resp = 1; resp_data = pend[0].data;
    end else resp_data = $urandom;
    br  = !late && (f_br || (k_br > 0 && ($urandom % 1000) < k_br));
    tgt = f_br ? f_tgt : ($urandom & 32'hFFFF_FFFC);
    f_br = 0; f_resp = 0;
    br_en = br; br_addr = tgt; resp_valid = resp;
    req_ready = late ? 1'b0 : (($urandom % 100) < k_req_rdy);
    dec_ready = ($urandom % 100) < k_dec_rdy;
    #1;
    live = 0;
    foreach (pend[i]) if (pend[i].live) live++;
    term  = br ? live : sb.size();
    exp_v = started && pend.size() < MAXO && term < DEPTH;
    chk("req_valid", mem_req_valid, exp_v);
    exp_a = br ? tgt : exp_pc;
    chk("req_addr", mem_req_addr, exp_a);
    fire = mem_req_valid && req_ready;
    if (resp && !late) void'(pend.pop_front());
    if (br) begin
      foreach (pend[i]) pend[i].live = 0;
      sb.delete();
    end
    if (fire) begin
      p.addr = exp_a; p.data = $urandom; p.live = 1;
      p.due = cyc + 1 + int'($urandom_range(0, lat_max));
      pend.push_back(p);
      e.pc = exp_a; e.instr = p.data;
      sb.push_back(e);
      exp_pc = exp_a + 32'd4;
      fires++;
      if (exp_a == 32'h0) saw_zero = 1;
    end else if (br) exp_pc = tgt;
    started = 1;
    cyc++;
    @(negedge clk);
  endtask

  // Decode-side monitor: every accepted head must match the scoreboard front.
  always @(negedge clk) begin
    #2;
    if (!reset) begin
      if (out_valid) begin
        if (dec_ready && !br_en) begin
          if (sb.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_out: pc %h instr %h, nothing owed", out_pc, out_instr);
          end else begin
            me = sb.pop_front();
            chk("out_pc", out_pc, me.pc);
            chk("out_pc_next", out_pc_next, me.pc + 32'd4);
            chk("out_instr", out_instr, me.instr);
          end
        end
      end else chk("idle_instr", out_instr, NOP_INSTR);
    end
  end

  task automatic do_reset(input int cycles);
    reset = 1; br_en = 0; req_ready = 0; dec_ready = 0; resp_valid = 0;
    pend.delete(); sb.delete(); exp_pc = 32'h1000; started = 0;
    repeat (cycles) @(negedge clk);
    chk("rst_req_valid", mem_req_valid, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_instr", out_instr, NOP_INSTR);
    chk("rst_pc", out_pc, 32'h1000);
    chk("rst_pc_next", out_pc_next, 32'h1004);
`ifdef FETCH_PERF_CNT_EN
    chk("rst_fetch_cnt", fetch_cnt, 0);
    chk("rst_flush_cnt", flush_cnt, 0);
`endif
    reset = 0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    k_req_rdy = 0; k_dec_rdy = 100; k_br = 0; k_resp = 100; lat_max = 0;
    while ((sb.size() > 0 || pend.size() > 0) && n < 60) begin step(); n++; end
    total++;
    if (sb.size() > 0 || pend.size() > 0) begin
      bad++;
      $display("FAIL %s_drain: %0d instr still owed, %0d in flight", name, sb.size(), pend.size());
    end
  endtask

  initial begin
    logic [31:0] a0;
    int n;
    @(negedge clk);

    // Free-flowing stream, minimum latency.
    do_reset(3);
    step();
    step();
    chk("lat_n1_valid", out_valid, 0);
    step();
    chk("lat_n2_valid", out_valid, 1);
    chk("lat_n2_pc", out_pc, 32'h1000);
    chk("lat_n2_pc_next", out_pc_next, 32'h1004);
    repeat (30) step();
    drain("stream");

    // Decode stalled: credit caps issue at the queue depth.
    k_dec_rdy = 0; k_req_rdy = 100; fires = 0;
    repeat (10) step();
    chk("fill_fires", fires, DEPTH);
    chk("fill_req_valid", mem_req_valid, 0);
    drain("fill");

    // Redirect in the cycle the oldest of two responses returns.
    do_reset(2);
    k_req_rdy = 100; k_dec_rdy = 100; k_resp = 0; fires = 0;
    repeat (3) step();
    chk("redir_setup_fires", fires, 2);
    f_br = 1; f_tgt = 32'h2000; f_resp = 1;
    step();
    k_resp = 100;
    n = 0;
    while (!out_valid && n < 10) begin step(); n++; end
    chk("redir_out_valid", out_valid, 1);
    chk("redir_first_pc", out_pc, 32'h2000);
`ifdef FETCH_PERF_CNT_EN
    chk("redir_flush_cnt", flush_cnt, 1);
`endif
    drain("redir");

    // Memory stall: address held, decode runs dry.
    k_req_rdy = 100; k_dec_rdy = 100;
    repeat (6) step();
    k_req_rdy = 0;
    a0 = mem_req_addr;
    repeat (5) begin step(); chk("stall_addr", mem_req_addr, a0); end
    chk("stall_out_valid", out_valid, 0);
    chk("stall_instr", out_instr, NOP_INSTR);
    drain("stall");

    // PC wrap past the top of the address space.
    k_req_rdy = 100; k_dec_rdy = 100; saw_zero = 0;
    f_br = 1; f_tgt = 32'hFFFF_FFF8;
    repeat (8) step();
    chk("wrap_zero_fetched", saw_zero, 1);
    drain("wrap");

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0) begin
        k_req_rdy = $urandom_range(30, 100);
        k_dec_rdy = $urandom_range(20, 100);
        k_br      = $urandom_range(0, 40);
        k_resp    = $urandom_range(30, 100);
        lat_max   = $urandom_range(0, 3);
      end
      step();
    end
    drain("random");

    // Reset with two requests in flight; their late responses must be ignored.
    k_req_rdy = 100; k_dec_rdy = 100; k_resp = 0;
    n = 0;
    while (pend.size() < 2 && n < 10) begin step(); n++; end
    chk("midrst_inflight", pend.size(), 2);
    late_cnt = pend.size();
    do_reset(2);
    k_resp = 100;
    fires = 0;
    repeat (8) step();
    chk("midrst_restart_fires", (fires > 0), 1);
    drain("midrst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
